// File: rtl/mac_accumulator_pkg.sv
// Shared definitions for the MAC accumulator: FSM states, default widths, mode encodings.
package mac_accumulator_pkg;

    localparam int unsigned ACC_W_DEFAULT = 40;
    localparam int unsigned LEN_W_DEFAULT = 8;

    // Accumulation mode, latched with start.
    localparam logic MODE_SINGLE = 1'b0;  // one signed 32-bit product per word
    localparam logic MODE_DUAL   = 1'b1;  // two packed signed 16-bit lane products

    typedef enum logic [1:0] {
        StIdle,
        StAccum,
        StDrain
    } state_e;

endpackage

// File: rtl/sat_lane_add.sv
// Signed saturating adder for one accumulator lane: acc + addend, clamped to the W-bit range.
module sat_lane_add #(
    parameter int unsigned W = 20
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] addend,  // already sign-extended to W bits
    output logic [W-1:0] result,
    output logic         ovf
);

    localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic [W:0] wide_sum;

    // One guard bit: overflow shows up as the guard bit disagreeing with the lane sign bit.
    always_comb begin
        wide_sum = {acc[W-1], acc} + {addend[W-1], addend};
        ovf      = wide_sum[W] ^ wide_sum[W-1];
        if (ovf) begin
            result = wide_sum[W] ? MIN_NEG : MAX_POS;
        end else begin
            result = wide_sum[W-1:0];
        end
    end

endmodule

// File: rtl/mac_accumulator.sv
// Accumulates a run of len products into a saturating sum, single-lane or dual 16-bit lane,
// and presents the result on a valid/ready output.
module mac_accumulator
    import mac_accumulator_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEFAULT,
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode,
    input  logic [31:0]      p,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] sum,
    output logic             sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned HALF_W = ACC_W / 2;

    state_e           state;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] count;
    logic             mode_r;

    logic [ACC_W-1:0]  full_addend;
    logic [HALF_W-1:0] hi_addend;
    logic [HALF_W-1:0] lo_addend;
    logic [ACC_W-1:0]  full_res;
    logic [HALF_W-1:0] hi_res;
    logic [HALF_W-1:0] lo_res;
    logic              full_ovf;
    logic              hi_ovf;
    logic              lo_ovf;
    logic [ACC_W-1:0]  acc_next;
    logic              ovf_now;
    logic [LEN_W-1:0]  count_next;

    // Sign-extend the product (whole word or each half) into its lane width.
    always_comb begin
        full_addend = {{(ACC_W-32){p[31]}}, p};
        hi_addend   = {{(HALF_W-16){p[31]}}, p[31:16]};
        lo_addend   = {{(HALF_W-16){p[15]}}, p[15:0]};
    end

    sat_lane_add #(
        .W(ACC_W)
    ) u_full_lane (
        .acc    (sum),
        .addend (full_addend),
        .result (full_res),
        .ovf    (full_ovf)
    );

    sat_lane_add #(
        .W(HALF_W)
    ) u_hi_lane (
        .acc    (sum[ACC_W-1:HALF_W]),
        .addend (hi_addend),
        .result (hi_res),
        .ovf    (hi_ovf)
    );

    sat_lane_add #(
        .W(HALF_W)
    ) u_lo_lane (
        .acc    (sum[HALF_W-1:0]),
        .addend (lo_addend),
        .result (lo_res),
        .ovf    (lo_ovf)
    );

    // Select the lane results for the latched mode; lanes never carry into each other.
    always_comb begin
        if (mode_r == MODE_DUAL) begin
            acc_next = {hi_res, lo_res};
            ovf_now  = hi_ovf | lo_ovf;
        end else begin
            acc_next = full_res;
            ovf_now  = full_ovf;
        end
        count_next = count + 1'b1;
    end

    // Run-control FSM with registered handshake outputs; sum doubles as the accumulator.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            len_r     <= '0;
            count     <= '0;
            mode_r    <= MODE_SINGLE;
            sum       <= '0;
            sat       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        len_r  <= len;
                        mode_r <= mode;
                        count  <= '0;
                        sum    <= '0;
                        sat    <= 1'b0;
                        if (len != '0) begin
                            state    <= StAccum;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= StDrain;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StAccum: begin
                    if (in_valid) begin
                        sum   <= acc_next;
                        sat   <= sat | ovf_now;
                        count <= count_next;
                        // count_next reaches at most len_r, so the counter never wraps.
                        if (count_next == len_r) begin
                            state     <= StDrain;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        state     <= StIdle;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= StIdle;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (40-bit instance plus a 34-bit instance
// sharing the same stimulus, so mode-0 clamping is reachable within a 255-product run).
module tb_mac_accumulator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        mode;
    logic [31:0] p;
    logic        in_valid;
    logic        out_ready;

    logic        in_ready;
    logic [39:0] sum;
    logic        sat;
    logic        out_valid;

    logic        in_ready34;
    logic [33:0] sum34;
    logic        sat34;
    logic        out_valid34;

    int checks;
    int errors;

    mac_accumulator #(
        .ACC_W(40),
        .LEN_W(8)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .mode      (mode),
        .p         (p),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mac_accumulator #(
        .ACC_W(34),
        .LEN_W(8)
    ) u_dut34 (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .mode      (mode),
        .p         (p),
        .in_valid  (in_valid),
        .in_ready  (in_ready34),
        .sum       (sum34),
        .sat       (sat34),
        .out_valid (out_valid34),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [7:0] n, input logic m);
        start = 1'b1;
        len   = n;
        mode  = m;
        tick();
        start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] word);
        in_valid = 1'b1;
        p        = word;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        len       = '0;
        mode      = 1'b0;
        p         = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check_eq("reset_sum", sum, 0);
        check_eq("reset_sat", sat, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        // in_valid in IDLE is dropped
        beat(32'd55);
        check_eq("idle_drop_sum", sum, 0);

        // Mode 0, len 4 with gaps: 10 - 3 + 100 + 7 = 114
        start_run(8'd4, 1'b0);
        check_eq("m0_in_ready_t1", in_ready, 1);
        beat(32'd10);
        tick();
        beat(32'hFFFF_FFFD);
        tick();
        tick();
        beat(32'd100);
        check_eq("m0_no_valid_early", out_valid, 0);
        beat(32'd7);
        check_eq("m0_out_valid", out_valid, 1);
        check_eq("m0_sum", sum, 64'd114);
        check_eq("m0_sat", sat, 0);
        check_eq("m0_in_ready_drain", in_ready, 0);
        handshake();
        check_eq("m0_idle_after_hs", out_valid, 0);

        // Mode 1, len 3, {2, -1} x3: hi 6, lo -3 as 20-bit lanes
        start_run(8'd3, 1'b1);
        for (int i = 0; i < 3; i++) beat(32'h0002_FFFF);
        check_eq("m1_sum", sum, 64'h00_0006_FFFFD);
        check_eq("m1_sat", sat, 0);
        handshake();

        // Mode 1 lane saturation: 20 x 0x7FFF exceeds 2^19-1, 20 x -0x8000 below -2^19
        start_run(8'd20, 1'b1);
        for (int i = 0; i < 20; i++) beat(32'h7FFF_8000);
        check_eq("m1_sat_sum", sum, 64'h7F_FFF8_0000);
        check_eq("m1_sat_flag", sat, 1);
        handshake();

        // Max run, mode 0: 255 x (2^31-1) = 0x7F7FFFFF01 fits in 40 bits, clamps in 34 bits
        start_run(8'd255, 1'b0);
        for (int i = 0; i < 254; i++) beat(32'h7FFF_FFFF);
        check_eq("max_no_valid_254", out_valid, 0);
        beat(32'h7FFF_FFFF);
        check_eq("max_out_valid", out_valid, 1);
        check_eq("max_sum40", sum, 64'h7F_7FFF_FF01);
        check_eq("max_sat40", sat, 0);
        check_eq("max_sum34", sum34, 64'h1_FFFF_FFFF);
        check_eq("max_sat34", sat34, 1);
        handshake();

        // Negative mode 0: 5 x -2^31 = -0x280000000; 34-bit clamps to -2^33
        start_run(8'd5, 1'b0);
        for (int i = 0; i < 5; i++) beat(32'h8000_0000);
        check_eq("neg_sum40", sum, 64'hFD_8000_0000);
        check_eq("neg_sat40", sat, 0);
        check_eq("neg_sum34", sum34, 64'h2_0000_0000);
        check_eq("neg_sat34", sat34, 1);
        handshake();

        // len 0: result straight away, held while out_ready low, start and beats ignored
        start_run(8'd0, 1'b0);
        check_eq("len0_out_valid", out_valid, 1);
        check_eq("len0_sum", sum, 0);
        for (int i = 0; i < 5; i++) begin
            start    = 1'b1;
            len      = 8'd3;
            in_valid = 1'b1;
            p        = 32'd123;
            tick();
            check_eq("len0_hold_sum", sum, 0);
            check_eq("len0_hold_valid", out_valid, 1);
            check_eq("len0_hold_in_ready", in_ready, 0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        handshake();
        check_eq("len0_idle_in_ready", in_ready, 0);
        check_eq("len0_idle_valid", out_valid, 0);

        // Asynchronous reset mid-run after 2 of 5 beats
        start_run(8'd5, 1'b0);
        beat(32'd100);
        beat(32'd100);
        reset = 1'b0;
        #1;
        check_eq("areset_sum", sum, 0);
        check_eq("areset_sat", sat, 0);
        check_eq("areset_in_ready", in_ready, 0);
        check_eq("areset_out_valid", out_valid, 0);
        #3;
        reset = 1'b1;
        tick();
        start_run(8'd1, 1'b0);
        beat(32'd5);
        check_eq("post_reset_valid", out_valid, 1);
        check_eq("post_reset_sum", sum, 64'd5);
        handshake();

        // Back-to-back: start at handshake cycle H ignored, start at H+1 accepted
        start_run(8'd1, 1'b0);
        beat(32'd9);
        check_eq("b2b_first_sum", sum, 64'd9);
        out_ready = 1'b1;
        start     = 1'b1;
        len       = 8'd2;
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        check_eq("b2b_h_ignored", in_ready, 0);
        check_eq("b2b_h_idle", out_valid, 0);
        start_run(8'd1, 1'b0);
        check_eq("b2b_h1_accepted", in_ready, 1);
        beat(32'd3);
        check_eq("b2b_second_sum", sum, 64'd3);
        check_eq("b2b_second_valid", out_valid, 1);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
